// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: credit-based prefetch buffer with branch redirect
// Optional performance counters are compiled in with FETCH_PERF_EN.
module instr_fetch #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [AW-1:0] im_addr,
    output logic          im_re,
    input  logic [31:0]   im_rdata,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    output logic          out_valid,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_pc,
    input  logic          out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]   perf_fetched,
    output logic [15:0]   perf_flushed
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_fetch_pc;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_pc_mem    [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_occupancy;
    logic          w_im_re;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;

    // A read in flight already owns a buffer slot, so it counts against the credit.
    assign w_occupancy  = r_count + CW'(r_inflight);
    assign w_head_valid = (r_count != '0);
    assign w_pop        = w_head_valid & out_ready;
    assign w_push       = r_inflight & ~redir_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_im_re     = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_im_re = (w_occupancy < DEPTH_C);
            end
            REFILL: begin
                w_im_re     = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
        if (redir_valid) begin
            w_im_re     = 1'b0;
            w_state_nxt = REFILL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= BOOT;
            r_fetch_pc    <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_im_re;
            if (redir_valid) begin
                r_fetch_pc <= redir_pc;
            end else if (w_im_re) begin
                r_fetch_pc    <= r_fetch_pc + 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redir_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: nothing is visible until r_count says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= im_rdata;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    assign im_re     = w_im_re;
    assign im_addr   = r_fetch_pc;
    assign out_valid = w_head_valid;
    assign out_instr = w_head_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign out_pc    = w_head_valid ? r_pc_mem[r_rd_ptr] : '0;

`ifdef FETCH_PERF_EN
    logic [15:0]   r_perf_fetched;
    logic [15:0]   r_perf_flushed;
    logic [CW-1:0] w_flush_cnt;
    logic [16:0]   w_flushed_sum;

    // The entry popped in a redirect cycle was delivered, not flushed.
    assign w_flush_cnt   = r_count - CW'(w_pop) + CW'(r_inflight);
    assign w_flushed_sum = {1'b0, r_perf_flushed} + 17'(w_flush_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != 16'hFFFF)) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (redir_valid) begin
                r_perf_flushed <= w_flushed_sum[16] ? 16'hFFFF : w_flushed_sum[15:0];
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
